// File: rtl/rh_temp_pkg.sv
// Shared definitions for the HDC1000-style I2C responder.
// State encoding, register pointers and default identity values.
package rh_temp_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    ADDR     = 4'd1,
    ADDR_ACK = 4'd2,
    PTR      = 4'd3,
    PTR_ACK  = 4'd4,
    WDATA_H  = 4'd5,
    WDATA_L  = 4'd6,
    WACK     = 4'd7,
    RDATA    = 4'd8,
    RACK     = 4'd9,
    IGNORE   = 4'd10
  } st_e;

  localparam logic [7:0] PTR_TEMP  = 8'h00;
  localparam logic [7:0] PTR_HUM   = 8'h01;
  localparam logic [7:0] PTR_CFG   = 8'h02;
  localparam logic [7:0] PTR_MANUF = 8'hFE;
  localparam logic [7:0] PTR_DEVID = 8'hFF;

  localparam logic [6:0]  ADDR_DEF   = 7'h40;
  localparam logic [15:0] CFG_DEF    = 16'h1000;
  localparam logic [15:0] MANUF_DEF  = 16'h5449;
  localparam logic [15:0] DEVID_DEF  = 16'h1000;

  function automatic logic is_conv_ptr(
    input logic [7:0] p
  );
    return (p == PTR_TEMP) || (p == PTR_HUM);
  endfunction

endpackage

// File: rtl/rh_temp_i2c_slave_if.sv
// I2C bus bundle seen by the responder.
// SDA_IN is the wired-AND line level; SDA_OE pulls it low.
interface rh_temp_i2c_slave_if;

  logic SCL_IN;
  logic SDA_IN;
  logic SDA_OE;

  modport slave (
    input  SCL_IN,
    input  SDA_IN,
    output SDA_OE
  );

  modport master (
    output SCL_IN,
    output SDA_IN,
    input  SDA_OE
  );

endinterface

// File: rtl/i2c_bus_sync.sv
// Two-flop synchronizer plus history flop for SCL/SDA.
// Emits SCL edge and START/STOP pulses, three clocks after the pin.
module i2c_bus_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_raw,
  input  logic sda_raw,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  // [0],[1] synchronize, [2] holds the previous synchronized value
  logic [2:0] scl_q;
  logic [2:0] sda_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_q <= '1;
      sda_q <= '1;
    end else begin
      scl_q <= {scl_q[1:0], scl_raw};
      sda_q <= {sda_q[1:0], sda_raw};
    end
  end

  assign sda      = sda_q[1];
  assign scl_rise = scl_q[1] & ~scl_q[2];
  assign scl_fall = ~scl_q[1] & scl_q[2];
  assign start    = scl_q[1] & scl_q[2]
                  & ~sda_q[1] & sda_q[2];
  assign stop     = scl_q[1] & scl_q[2]
                  & sda_q[1] & ~sda_q[2];

endmodule

// File: rtl/rh_temp_i2c_slave.sv
// HDC1000 emulator: pointer/word-write/read register file with DRDY_n.
// Define RH_TEMP_SLAVE_SOFTRESET_EN to make config bit 15 a soft reset.
module rh_temp_i2c_slave
  import rh_temp_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADDR7 = ADDR_DEF,
  parameter int unsigned CONV_CYCLES = 32500,
  parameter logic [15:0] CONFIG_RST  = CFG_DEF,
  parameter logic [15:0] MANUF_ID    = MANUF_DEF,
  parameter logic [15:0] DEVICE_ID   = DEVID_DEF
) (
  input  logic        CLK_50,
  input  logic        RESET_N,
  rh_temp_i2c_slave_if.slave bus,
  output logic        DRDY_n,
  input  logic [15:0] TEMP_VALUE,
  input  logic [15:0] HUM_VALUE,
  output logic [15:0] Configuration,
  output logic [7:0]  ST
);

  localparam logic [15:0] CONV_LOAD = 16'(CONV_CYCLES);

  logic sda, scl_rise, scl_fall, start, stop;

  i2c_bus_sync u_sync (
    .clk      (CLK_50),
    .rst_n    (RESET_N),
    .scl_raw  (bus.SCL_IN),
    .sda_raw  (bus.SDA_IN),
    .sda      (sda),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  st_e         state;
  logic        sda_oe;
  logic [3:0]  bit_cnt;
  logic [7:0]  shreg;
  logic [7:0]  txreg;
  logic [7:0]  ptr;
  logic [7:0]  data_h;
  logic [15:0] temp_sh;
  logic [15:0] hum_sh;
  logic [15:0] conv_cnt;
  logic        rw;
  logic        ack_n;
  logic        wr_done;
  logic [1:0]  rbyte;

  logic [15:0] base_word;
  logic [15:0] rd_word;
  logic [7:0]  rd_byte;
  logic [1:0]  rbyte_nxt;
  logic        four_byte;
  logic        byte_done;
  logic        addr_hit;
  logic        shifting;

  assign bus.SDA_OE = sda_oe;
  assign ST         = {4'b0000, state};

  always_comb begin
    base_word = 16'h0000;
    unique case (1'b1)
      ptr == PTR_TEMP:  base_word = temp_sh;
      ptr == PTR_HUM:   base_word = hum_sh;
      ptr == PTR_CFG:   base_word = Configuration;
      ptr == PTR_MANUF: base_word = MANUF_ID;
      ptr == PTR_DEVID: base_word = DEVICE_ID;
      default:          base_word = 16'h0000;
    endcase
  end

  // Bytes 3-4 only exist for the combined temperature+humidity read
  assign four_byte = Configuration[12] && (ptr == PTR_TEMP);
  assign rd_word   = rbyte[1] ? hum_sh : base_word;
  assign rd_byte   = rbyte[0] ? rd_word[7:0] : rd_word[15:8];
  assign rbyte_nxt =
    ((rbyte == 2'd3) || (!four_byte && rbyte == 2'd1))
      ? 2'd0 : rbyte + 2'd1;

  assign byte_done = (bit_cnt == 4'd8);
  assign addr_hit  = (shreg[7:1] == SLAVE_ADDR7);
  assign shifting  = (state == ADDR) || (state == PTR)
                  || (state == WDATA_H) || (state == WDATA_L);

  always_ff @(posedge CLK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state         <= IDLE;
      sda_oe        <= 1'b0;
      bit_cnt       <= 4'd0;
      shreg         <= 8'h00;
      txreg         <= 8'h00;
      ptr           <= PTR_TEMP;
      data_h        <= 8'h00;
      temp_sh       <= 16'h0000;
      hum_sh        <= 16'h0000;
      conv_cnt      <= 16'h0000;
      rw            <= 1'b0;
      ack_n         <= 1'b1;
      wr_done       <= 1'b0;
      rbyte         <= 2'd0;
      DRDY_n        <= 1'b1;
      Configuration <= CONFIG_RST;
    end else begin
      // Bus-side assignments below override this on a trigger
      if (conv_cnt != 16'h0000) begin
        conv_cnt <= conv_cnt - 16'd1;
        if (conv_cnt == 16'd1) begin
          temp_sh <= TEMP_VALUE;
          hum_sh  <= HUM_VALUE;
          DRDY_n  <= 1'b0;
        end
      end
      if (stop) begin
        state  <= IDLE;
        sda_oe <= 1'b0;
      end else if (start) begin
        state   <= ADDR;
        bit_cnt <= 4'd0;
        sda_oe  <= 1'b0;
      end else if (scl_rise) begin
        if (shifting && !byte_done) begin
          shreg   <= {shreg[6:0], sda};
          bit_cnt <= bit_cnt + 4'd1;
        end
        if (state == RACK) ack_n <= sda;
      end else if (scl_fall) begin
        unique case (state)
          ADDR: if (byte_done) begin
            bit_cnt <= 4'd0;
            if (!addr_hit) begin
              state <= IGNORE;
            end else if (shreg[0] && is_conv_ptr(ptr)
                         && DRDY_n) begin
              state <= IGNORE;
            end else begin
              state  <= ADDR_ACK;
              sda_oe <= 1'b1;
              rw     <= shreg[0];
              rbyte  <= 2'd0;
            end
          end
          ADDR_ACK: begin
            if (rw) begin
              state   <= RDATA;
              txreg   <= rd_byte;
              sda_oe  <= ~rd_byte[7];
              bit_cnt <= 4'd0;
            end else begin
              state  <= PTR;
              sda_oe <= 1'b0;
            end
          end
          PTR: if (byte_done) begin
            ptr     <= shreg;
            bit_cnt <= 4'd0;
            state   <= PTR_ACK;
            sda_oe  <= 1'b1;
            if (is_conv_ptr(shreg)) begin
              conv_cnt <= CONV_LOAD;
              DRDY_n   <= 1'b1;
            end
          end
          PTR_ACK: begin
            state   <= WDATA_H;
            sda_oe  <= 1'b0;
            wr_done <= 1'b0;
          end
          WDATA_H: if (byte_done) begin
            data_h  <= shreg;
            bit_cnt <= 4'd0;
            state   <= WACK;
            sda_oe  <= 1'b1;
          end
          WDATA_L: if (byte_done) begin
            bit_cnt <= 4'd0;
            state   <= WACK;
            sda_oe  <= 1'b1;
            wr_done <= 1'b1;
            if (!wr_done && ptr == PTR_CFG) begin
`ifdef RH_TEMP_SLAVE_SOFTRESET_EN
              if (data_h[7]) begin
                Configuration <= CONFIG_RST;
                conv_cnt      <= 16'h0000;
                DRDY_n        <= 1'b1;
                temp_sh       <= 16'h0000;
                hum_sh        <= 16'h0000;
              end else begin
                Configuration <= {data_h, shreg};
              end
`else
              Configuration <= {data_h, shreg};
`endif
            end
          end
          WACK: begin
            state  <= WDATA_L;
            sda_oe <= 1'b0;
          end
          RDATA: begin
            if (bit_cnt == 4'd7) begin
              sda_oe <= 1'b0;
              state  <= RACK;
              rbyte  <= rbyte_nxt;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
              txreg   <= {txreg[6:0], 1'b0};
              sda_oe  <= ~txreg[6];
            end
          end
          RACK: begin
            if (ack_n) begin
              state <= IGNORE;
            end else begin
              state   <= RDATA;
              txreg   <= rd_byte;
              sda_oe  <= ~rd_byte[7];
              bit_cnt <= 4'd0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rh_temp_i2c_slave.sv
// Directed bench for rh_temp_i2c_slave driving a bit-banged I2C master.
// Honours RH_TEMP_SLAVE_SOFTRESET_EN for the config bit-15 scenario.
module tb_rh_temp_i2c_slave;

  localparam int CONV = 600;
  localparam int Q    = 6;

  logic        CLK_50  = 1'b0;
  logic        RESET_N = 1'b0;
  logic        m_sda   = 1'b1;
  logic        DRDY_n;
  logic [15:0] TEMP_VALUE = 16'h0000;
  logic [15:0] HUM_VALUE  = 16'h0000;
  logic [15:0] Configuration;
  logic [7:0]  ST;

  int checks   = 0;
  int failures = 0;

  rh_temp_i2c_slave_if bus_if ();

  assign bus_if.SDA_IN = m_sda & ~bus_if.SDA_OE;

  rh_temp_i2c_slave #(.CONV_CYCLES(CONV)) dut (
    .CLK_50        (CLK_50),
    .RESET_N       (RESET_N),
    .bus           (bus_if),
    .DRDY_n        (DRDY_n),
    .TEMP_VALUE    (TEMP_VALUE),
    .HUM_VALUE     (HUM_VALUE),
    .Configuration (Configuration),
    .ST            (ST)
  );

  always #5 CLK_50 = ~CLK_50;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK_50);
    #1;
  endtask

  task automatic i2c_start();
    cyc(Q); m_sda = 1'b1;
    cyc(Q); bus_if.SCL_IN = 1'b1;
    cyc(Q); m_sda = 1'b0;
    cyc(Q); bus_if.SCL_IN = 1'b0;
  endtask

  task automatic i2c_stop();
    cyc(Q); m_sda = 1'b0;
    cyc(Q); bus_if.SCL_IN = 1'b1;
    cyc(Q); m_sda = 1'b1;
    cyc(Q);
  endtask

  task automatic write_byte(input logic [7:0] b,
                            output logic ack_n);
    for (int i = 7; i >= 0; i--) begin
      cyc(Q); m_sda = b[i];
      cyc(Q); bus_if.SCL_IN = 1'b1;
      cyc(2*Q); bus_if.SCL_IN = 1'b0;
    end
    cyc(Q); m_sda = 1'b1;
    cyc(Q); bus_if.SCL_IN = 1'b1;
    cyc(Q); ack_n = bus_if.SDA_IN;
    cyc(Q); bus_if.SCL_IN = 1'b0;
  endtask

  task automatic read_byte(input logic nack,
                           output logic [7:0] b);
    b = 8'h00;
    m_sda = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc(2*Q); bus_if.SCL_IN = 1'b1;
      cyc(Q); b = {b[6:0], bus_if.SDA_IN};
      cyc(Q); bus_if.SCL_IN = 1'b0;
    end
    cyc(Q); m_sda = nack;
    cyc(Q); bus_if.SCL_IN = 1'b1;
    cyc(2*Q); bus_if.SCL_IN = 1'b0;
  endtask

  task automatic set_ptr(input logic [7:0] p,
                         output logic [1:0] acks);
    i2c_start();
    write_byte(8'h80, acks[1]);
    write_byte(p, acks[0]);
    i2c_stop();
  endtask

  task automatic read_n(input int n,
                        output logic [39:0] data,
                        output logic a_n);
    logic [7:0] b;
    data = '0;
    i2c_start();
    write_byte(8'h81, a_n);
    if (!a_n) begin
      for (int i = 0; i < n; i++) begin
        read_byte(i == n - 1, b);
        data = {data[31:0], b};
      end
    end
    i2c_stop();
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    bus_if.SCL_IN = 1'b1;
    m_sda = 1'b1;
    cyc(5);
    checks++;
    if (bus_if.SDA_OE !== 1'b0) begin
      failures++;
      $display("FAIL rst_sda_oe got=%b exp=0", bus_if.SDA_OE);
    end
    checks++;
    if (DRDY_n !== 1'b1) begin
      failures++;
      $display("FAIL rst_drdy got=%b exp=1", DRDY_n);
    end
    checks++;
    if (Configuration !== 16'h1000) begin
      failures++;
      $display("FAIL rst_cfg got=%h exp=1000", Configuration);
    end
    RESET_N = 1'b1;
    cyc(5);
    checks++;
    if (ST !== 8'd0) begin
      failures++;
      $display("FAIL rst_st got=%0d exp=0", ST);
    end
  endtask

  task automatic test_config_write();
    logic [4:0] a;
    i2c_start();
    write_byte(8'h80, a[4]);
    write_byte(8'h02, a[3]);
    write_byte(8'h01, a[2]);
    write_byte(8'h55, a[1]);
    checks++;
    if (Configuration !== 16'h0155) begin
      failures++;
      $display("FAIL cfg_0155 got=%h exp=0155", Configuration);
    end
    write_byte(8'hAB, a[0]);
    i2c_stop();
    checks++;
    if (a !== 5'b00000) begin
      failures++;
      $display("FAIL cfg_acks1 got=%b exp=00000", a);
    end
    checks++;
    if (Configuration !== 16'h0155) begin
      failures++;
      $display("FAIL cfg_extra got=%h exp=0155", Configuration);
    end
    i2c_start();
    write_byte(8'h80, a[3]);
    write_byte(8'h02, a[2]);
    write_byte(8'h10, a[1]);
    write_byte(8'h00, a[0]);
    i2c_stop();
    checks++;
    if (a[3:0] !== 4'b0000) begin
      failures++;
      $display("FAIL cfg_acks2 got=%b exp=0000", a[3:0]);
    end
    checks++;
    if (Configuration !== 16'h1000) begin
      failures++;
      $display("FAIL cfg_1000 got=%h exp=1000", Configuration);
    end
    checks++;
    if (ST !== 8'd0) begin
      failures++;
      $display("FAIL cfg_idle got=%0d exp=0", ST);
    end
  endtask

  task automatic test_id_read();
    logic [1:0]  pa;
    logic [39:0] d;
    logic        an;
    set_ptr(8'hFF, pa);
    read_n(2, d, an);
    checks++;
    if (pa !== 2'b00 || an !== 1'b0 || d[15:0] !== 16'h1000) begin
      failures++;
      $display("FAIL id_dev got=%h ack=%b%b exp=1000",
               d[15:0], pa, an);
    end
    set_ptr(8'hFE, pa);
    read_n(3, d, an);
    checks++;
    if (an !== 1'b0 || d[23:0] !== 24'h544954) begin
      failures++;
      $display("FAIL id_manuf_wrap got=%h exp=544954", d[23:0]);
    end
    set_ptr(8'h02, pa);
    read_n(2, d, an);
    checks++;
    if (an !== 1'b0 || d[15:0] !== 16'h1000) begin
      failures++;
      $display("FAIL id_cfg got=%h exp=1000", d[15:0]);
    end
    set_ptr(8'h37, pa);
    read_n(2, d, an);
    checks++;
    if (an !== 1'b0 || d[15:0] !== 16'h0000) begin
      failures++;
      $display("FAIL id_other got=%h exp=0000", d[15:0]);
    end
  endtask

  task automatic test_conversion();
    logic [1:0]  pa;
    logic [39:0] d;
    logic        an, a0, a1;
    TEMP_VALUE = 16'h6640;
    HUM_VALUE  = 16'h8000;
    set_ptr(8'h01, pa);
    cyc(CONV + 50);
    checks++;
    if (DRDY_n !== 1'b0) begin
      failures++;
      $display("FAIL conv_done1 got=%b exp=0", DRDY_n);
    end
    i2c_start();
    write_byte(8'h80, a1);
    write_byte(8'h00, a0);
    checks++;
    if (DRDY_n !== 1'b1 || a1 !== 1'b0 || a0 !== 1'b0) begin
      failures++;
      $display("FAIL conv_trig got=%b exp=1", DRDY_n);
    end
    i2c_stop();
    read_n(2, d, an);
    checks++;
    if (an !== 1'b1) begin
      failures++;
      $display("FAIL conv_busy_nack got=%b exp=1", an);
    end
    cyc(CONV + 50);
    checks++;
    if (DRDY_n !== 1'b0) begin
      failures++;
      $display("FAIL conv_done2 got=%b exp=0", DRDY_n);
    end
    read_n(2, d, an);
    checks++;
    if (an !== 1'b0 || d[15:0] !== 16'h6640) begin
      failures++;
      $display("FAIL conv_temp got=%h exp=6640", d[15:0]);
    end
    checks++;
    if (DRDY_n !== 1'b0) begin
      failures++;
      $display("FAIL conv_keep got=%b exp=0", DRDY_n);
    end
  endtask

  task automatic test_four_byte();
    logic [39:0] d;
    logic        an;
    TEMP_VALUE = 16'h1111;
    read_n(5, d, an);
    checks++;
    if (an !== 1'b0 || d !== 40'h6640800066) begin
      failures++;
      $display("FAIL four_byte got=%h exp=6640800066", d);
    end
  endtask

  task automatic test_bad_addr();
    logic       a, b;
    logic [3:0] w;
    i2c_start();
    write_byte(8'h82, a);
    checks++;
    if (a !== 1'b1 || ST !== 8'd10) begin
      failures++;
      $display("FAIL bad_addr ack=%b st=%0d exp=1/10", a, ST);
    end
    write_byte(8'h00, b);
    checks++;
    if (b !== 1'b1 || bus_if.SDA_OE !== 1'b0) begin
      failures++;
      $display("FAIL bad_quiet ack=%b oe=%b exp=1/0",
               b, bus_if.SDA_OE);
    end
    i2c_stop();
    checks++;
    if (ST !== 8'd0) begin
      failures++;
      $display("FAIL bad_stop st=%0d exp=0", ST);
    end
    i2c_start();
    write_byte(8'h80, w[3]);
    write_byte(8'h02, w[2]);
    write_byte(8'h12, w[1]);
    i2c_start();
    checks++;
    if (ST !== 8'd1) begin
      failures++;
      $display("FAIL rstart_st got=%0d exp=1", ST);
    end
    write_byte(8'h80, w[0]);
    write_byte(8'h02, a);
    write_byte(8'h30, b);
    write_byte(8'h00, w[1]);
    i2c_stop();
    checks++;
    if (Configuration !== 16'h3000 || w !== 4'b0000
        || a !== 1'b0 || b !== 1'b0) begin
      failures++;
      $display("FAIL rstart_cfg got=%h exp=3000", Configuration);
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] pa;
    logic       a;
    set_ptr(8'hFE, pa);
    i2c_start();
    write_byte(8'h81, a);
    cyc(Q);
    checks++;
    if (bus_if.SDA_OE !== 1'b1 || a !== 1'b0) begin
      failures++;
      $display("FAIL mid_drive oe=%b exp=1", bus_if.SDA_OE);
    end
    #3;
    RESET_N = 1'b0;
    #1;
    checks++;
    if (bus_if.SDA_OE !== 1'b0) begin
      failures++;
      $display("FAIL mid_release oe=%b exp=0", bus_if.SDA_OE);
    end
    cyc(2);
    checks++;
    if (Configuration !== 16'h1000 || ST !== 8'd0
        || DRDY_n !== 1'b1) begin
      failures++;
      $display("FAIL mid_state cfg=%h st=%0d drdy=%b exp=1000/0/1",
               Configuration, ST, DRDY_n);
    end
    RESET_N = 1'b1;
    cyc(4);
    i2c_stop();
  endtask

  task automatic test_softreset();
    logic [1:0] pa;
    logic [3:0] w;
    set_ptr(8'h00, pa);
    cyc(CONV + 50);
    checks++;
    if (DRDY_n !== 1'b0) begin
      failures++;
      $display("FAIL sr_pre got=%b exp=0", DRDY_n);
    end
    i2c_start();
    write_byte(8'h80, w[3]);
    write_byte(8'h02, w[2]);
    write_byte(8'h80, w[1]);
    write_byte(8'h00, w[0]);
    i2c_stop();
`ifdef RH_TEMP_SLAVE_SOFTRESET_EN
    checks++;
    if (Configuration !== 16'h1000 || DRDY_n !== 1'b1) begin
      failures++;
      $display("FAIL softreset cfg=%h drdy=%b exp=1000/1",
               Configuration, DRDY_n);
    end
`else
    checks++;
    if (Configuration !== 16'h8000 || DRDY_n !== 1'b0) begin
      failures++;
      $display("FAIL bit15_store cfg=%h drdy=%b exp=8000/0",
               Configuration, DRDY_n);
    end
`endif
  endtask

  initial begin
    bus_if.SCL_IN = 1'b1;
    test_reset();
    test_config_write();
    test_id_read();
    test_conversion();
    test_four_byte();
    test_bad_addr();
    test_reset_mid();
    test_softreset();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/rh_temp_i2c_slave.md
Name: rh_temp_i2c_slave

Overview:
- I2C responder that emulates the HDC1000 humidity/temperature sensor at the far end of the bus from the existing I2C master.
- Used for on-board loopback and bench verification of the master without the physical sensor.
- Decodes the pointer/word-write/read protocol and serves a register file: temperature, humidity, configuration, manufacturer ID, device ID.
- Models conversion time and the DRDY_n handshake.

Parameters:
SLAVE_ADDR7, 7'h40, 7-bit address (8'h80 on the wire for write)
CONV_CYCLES, 32500, CLK_50 cycles from conversion trigger to data ready (650 us)
CONFIG_RST, 16'h1000, configuration reset value
MANUF_ID, 16'h5449, value returned for pointer 8'hFE
DEVICE_ID, 16'h1000, value returned for pointer 8'hFF

Ports:
CLK_50  in  1  system clock; all logic is synchronous to it
RESET_N  in  1  asynchronous active-low reset
SCL_IN  in  1  bus SCL, asynchronous
SDA_IN  in  1  bus SDA, asynchronous
SDA_OE  out  1  1 = pull SDA low (open drain); top level ties it to the pad
DRDY_n  out  1  low = conversion result valid
TEMP_VALUE  in  16  raw temperature sampled at end of conversion
HUM_VALUE  in  16  raw humidity sampled at end of conversion
Configuration  out  16  current configuration register
ST  out  8  state, for test

Behaviour:
- Reset values:
  - SDA_OE=0, DRDY_n=1, Configuration=CONFIG_RST, ST=IDLE.
  - Pointer=8'h00; temperature/humidity shadows=0; conversion counter=0.
- Input sampling and edge detection:
  - SCL_IN and SDA_IN each pass through a 2-FF synchronizer plus one history FF.
  - Edges are detected in CLK_50, giving 3-cycle latency.
- Bus conditions:
  - START = SDA falls while SCL high. STOP = SDA rises while SCL high.
  - START in any state, including a repeated start, goes to ADDR with the bit counter cleared.
  - STOP in any state goes to IDLE and sets SDA_OE=0.
- Bit timing: data is sampled on SCL rise. SDA_OE changes only on SCL fall.
- State machine:
  - IDLE -> ADDR: shift 8 bits.
    - Address mismatch -> IGNORE until START/STOP.
    - Match -> ADDR_ACK: SDA_OE=1 for one SCL low/high period.
  - R/W=0 -> PTR: shift pointer byte, ACK it. Pointer is updated at the ACK.
    - Pointer 8'h00 or 8'h01 triggers a conversion.
  - Then WDATA_H, ACK, WDATA_L, ACK.
    - If pointer=8'h02, Configuration <= {H,L} at the second ACK.
    - Other pointers: data bytes are ACKed and discarded.
    - Further bytes are ACKed and discarded.
  - R/W=1, data path:
    - If pointer is 8'h00/8'h01 and DRDY_n=1, the address is NACKed and the FSM goes to IGNORE.
    - Otherwise ACK -> RDATA: drive MSB byte, then LSB byte, MSB-first, releasing SDA for '1' bits.
    - RACK samples the master ACK: ACK continues with the next byte; NACK -> IGNORE.
  - Read mux:
    - 00 -> temperature shadow; 01 -> humidity shadow; 02 -> Configuration.
    - FE -> MANUF_ID; FF -> DEVICE_ID; any other pointer -> 16'h0000.
    - If Configuration[12]=1 and pointer=00, bytes 3-4 return the humidity shadow.
    - Beyond the available bytes the sequence wraps to byte 1.
- Conversion:
  - On trigger: DRDY_n=1 and counter=CONV_CYCLES.
  - Counter decrements each CLK_50. At 1 it latches TEMP_VALUE and HUM_VALUE into the shadows and sets DRDY_n=0.
  - A re-trigger during conversion restarts the count.
  - A completed read of pointer 00/01 (master NACK) leaves DRDY_n low.
- Reset mid-transfer: bus is released immediately (SDA_OE=0 asynchronously) and all state is cleared.

Optional Feature:
Macro RH_TEMP_SLAVE_SOFTRESET_EN.
- Defined: a configuration write with bit 15 = 1 restores Configuration to CONFIG_RST, aborts any conversion, sets DRDY_n=1, and clears the shadows. The written value is not stored.
- Undefined: bit 15 is stored like any other bit, with no side effects.

Decomposition:
- Package rh_temp_pkg holds:
  - state encoding (IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA_H, WDATA_L, WACK, RDATA, RACK, IGNORE);
  - pointer constants 00/01/02/FE/FF;
  - default IDs.
- Sub-module i2c_bus_sync (2-FF sync, SCL rise/fall, START/STOP pulses) is natural and reusable.

Test Plan:
- Write 0x80, 0x02, 0x10, 0x00 -> four ACKs; Configuration=16'h1000 after the second data ACK.
- Write 0x80, 0xFF, STOP; then read 0x81 -> bytes 0x10, 0x00 (DEVICE_ID); pointer FE -> 0x54, 0x49.
- Pointer write 0x00 -> DRDY_n=1 immediately.
  - Read of 0x81 before CONV_CYCLES elapse -> address NACK.
  - After CONV_CYCLES, DRDY_n=0 and the read returns TEMP_VALUE (e.g. 16'h6640).
- Configuration[12]=1, 4-byte read at pointer 00 with TEMP=16'h6640, HUM=16'h8000 -> 66, 40, 80, 00.
- Address 0x82 -> no ACK, SDA_OE stays 0 until STOP.
  - Repeated START inside a write -> ADDR restarts cleanly.
- RESET_N pulsed low during RDATA while driving 0 -> SDA_OE=0 the same cycle; Configuration=16'h1000.
  - With the macro defined, writing 0x8000 to config -> Configuration=16'h1000 and DRDY_n=1.
